// File: rtl/button_gesture.sv
// button_gesture: classifies a debounced button level into press/release edges and short/long/double gestures.
// The release-edge pulse port is named rel because release is a reserved word.
module button_gesture #(
  parameter int CW = 24,
  parameter logic [CW-1:0] LONG_CYCLES = 24'd6000000,
  parameter logic [CW-1:0] GAP_CYCLES = 24'd3000000
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic press,
  output logic rel,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic long_active
);
  typedef enum logic [2:0] {IDLE, DOWN1, LONG, WAIT2, DOWN2} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic lvl_r;
  logic press_n, rel_n, short_n, long_n, double_n;
  always_comb begin
    state_n = state;
    press_n = 1'b0;
    rel_n = 1'b0;
    short_n = 1'b0;
    long_n = 1'b0;
    double_n = 1'b0;
    case (state)
      IDLE:
        if (lvl_r) begin
          state_n = DOWN1;
          press_n = 1'b1;
        end
      DOWN1:
        if (!lvl_r) begin
          state_n = WAIT2;
          rel_n = 1'b1;
        end else if (cnt == LONG_CYCLES - 1'b1) begin
          state_n = LONG;
          long_n = 1'b1;
        end
      LONG:
        if (!lvl_r) begin
          state_n = IDLE;
          rel_n = 1'b1;
        end
      WAIT2:
        if (lvl_r) begin
          state_n = DOWN2;
          press_n = 1'b1;
          double_n = 1'b1;
        end else if (cnt == GAP_CYCLES - 1'b1) begin
          state_n = IDLE;
          short_n = 1'b1;
        end
      DOWN2:
        if (!lvl_r) begin
          state_n = IDLE;
          rel_n = 1'b1;
        end
      default: state_n = IDLE;
    endcase
    // counter runs only while remaining in a timed state; any entry clears it
    cnt_n = (state_n == state && (state == DOWN1 || state == WAIT2)) ? cnt + 1'b1 : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      lvl_r <= 1'b0;
      press <= 1'b0;
      rel <= 1'b0;
      short_press <= 1'b0;
      long_press <= 1'b0;
      double_press <= 1'b0;
      long_active <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      lvl_r <= level;
      press <= press_n;
      rel <= rel_n;
      short_press <= short_n;
      long_press <= long_n;
      double_press <= double_n;
      long_active <= state_n == LONG;
    end
  end
endmodule

// File: tb/tb_button_gesture.sv
// tb_button_gesture: directed cycle-by-cycle checks of all gesture outputs with LONG=8, GAP=6.
module tb_button_gesture;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic level = 1'b0;
  logic press, rel, short_press, long_press, double_press, long_active;
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  string tag = "init";
  localparam logic [5:0] Z = 6'b000000, P = 6'b100000, R = 6'b010000, S = 6'b001000;
  localparam logic [5:0] L = 6'b000100, D = 6'b000010, A = 6'b000001;

  button_gesture #(.CW(24), .LONG_CYCLES(24'd8), .GAP_CYCLES(24'd6)) dut (
    .clk(clk), .rst(rst), .level(level), .press(press), .rel(rel),
    .short_press(short_press), .long_press(long_press), .double_press(double_press),
    .long_active(long_active)
  );

  always #5 clk = ~clk;

  task automatic s(input logic l, input logic [5:0] e);
    logic [5:0] o;
    level = l;
    @(posedge clk);
    #1;
    cyc++;
    o = {press, rel, short_press, long_press, double_press, long_active};
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s cyc %0d: outs(P R S L D A)=%b expected %b", tag, cyc, o, e);
    end
  endtask

  task automatic run(input int n, input logic l, input logic [5:0] e);
    for (int i = 0; i < n; i++) s(l, e);
  endtask

  initial begin
    tag = "reset";
    rst = 1'b0;
    s(1, Z); s(0, Z); s(1, Z);
    rst = 1'b1;
    s(0, Z); s(0, Z);

    tag = "short";
    s(1, Z); s(1, P); s(1, Z); s(0, Z); s(0, R);
    run(5, 0, Z);
    s(0, S);
    run(5, 0, Z);

    tag = "long";
    s(1, Z); s(1, P);
    run(7, 1, Z);
    s(1, L | A);
    run(10, 1, A);
    s(0, A); s(0, R);
    run(8, 0, Z);

    tag = "double";
    s(1, Z); s(1, P); s(1, Z); s(0, Z); s(0, R);
    s(1, Z); s(1, P | D); s(1, Z); s(0, Z); s(0, R);
    run(8, 0, Z);

    tag = "gap6";
    s(1, Z); s(1, P); s(0, Z); s(0, R);
    run(4, 0, Z);
    s(1, Z); s(1, P | D); s(0, Z); s(0, R);
    run(8, 0, Z);

    tag = "gap7";
    s(1, Z); s(1, P); s(0, Z); s(0, R);
    run(5, 0, Z);
    s(1, S); s(1, P); s(0, Z); s(0, R);
    run(5, 0, Z);
    s(0, S);
    run(3, 0, Z);

    tag = "abort";
    s(1, Z); s(1, P); s(0, Z); s(0, R); s(0, Z);
    rst = 1'b0;
    s(0, Z);
    rst = 1'b1;
    run(8, 0, Z);
    s(1, Z); s(1, P); s(0, Z); s(0, R);
    run(5, 0, Z);
    s(0, S);

    tag = "held_out_of_reset";
    rst = 1'b0;
    s(1, Z);
    rst = 1'b1;
    s(1, Z); s(1, P); s(0, Z); s(0, R);
    run(5, 0, Z);
    s(0, S);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
